// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: canonical NOP, base opcodes and fetch FSM states.
package riscv_pkg;

  // addi x0, x0, 0
  localparam logic [31:0] InstrNop = 32'h0000_0013;

  // Base opcode field (instr[6:0]); also used by the immediate generator.
  localparam logic [6:0] OpcodeLoad    = 7'b000_0011;
  localparam logic [6:0] OpcodeMiscMem = 7'b000_1111;
  localparam logic [6:0] OpcodeOpImm   = 7'b001_0011;
  localparam logic [6:0] OpcodeAuipc   = 7'b001_0111;
  localparam logic [6:0] OpcodeStore   = 7'b010_0011;
  localparam logic [6:0] OpcodeOp      = 7'b011_0011;
  localparam logic [6:0] OpcodeLui     = 7'b011_0111;
  localparam logic [6:0] OpcodeBranch  = 7'b110_0011;
  localparam logic [6:0] OpcodeJalr    = 7'b110_0111;
  localparam logic [6:0] OpcodeJal     = 7'b110_1111;
  localparam logic [6:0] OpcodeSystem  = 7'b111_0011;

  typedef enum logic [2:0] {
    StReset,
    StReq,
    StWait,
    StHold,
    StDrop
  } fetch_state_e;

  // Force an address onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps at most one memory request in flight,
// buffers a returned word while decode is stalled and squashes in-flight data on redirect.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_q, hold_d;
  logic         if_valid_q, if_valid_d;
  logic [31:0]  if_instr_q, if_instr_d;
  logic [31:0]  if_pc_q, if_pc_d;

  logic         slot_free;
  logic         awaiting_rsp;
  logic         deliver;
  logic [31:0]  deliver_data;

  // Output slot can take a new word if it is empty or decode consumes it this cycle.
  always_comb begin
    slot_free = !if_valid_q || !stall;
  end

  // Next-state logic: redirect wins over everything, otherwise the FSM advances.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_d       = hold_q;
    // Decode takes the word whenever it is not stalled; nothing new means the slot empties.
    if_valid_d   = if_valid_q && stall;
    if_instr_d   = if_instr_q;
    if_pc_d      = if_pc_q;
    awaiting_rsp = 1'b0;
    deliver      = 1'b0;
    deliver_data = hold_q;

    if (redirect_valid) begin
      pc_d       = align_word(redirect_pc);
      if_valid_d = 1'b0;
      // A request is still owed a response if it was accepted but not yet answered.
      // A response arriving this very cycle settles the debt and is simply dropped.
      unique case (state_q)
        StReq:         awaiting_rsp = imem_req_ready;
        StWait, StDrop: awaiting_rsp = !imem_rsp_valid;
        default:       awaiting_rsp = 1'b0;
      endcase
      state_d = awaiting_rsp ? StDrop : StReq;
    end else begin
      unique case (state_q)
        StReset: begin
          state_d = StReq;
        end
        StReq: begin
          if (imem_req_ready) begin
            state_d = StWait;
          end
        end
        StWait: begin
          if (imem_rsp_valid) begin
            if (slot_free) begin
              deliver      = 1'b1;
              deliver_data = imem_rsp_data;
            end else begin
              hold_d  = imem_rsp_data;
              state_d = StHold;
            end
          end
        end
        StHold: begin
          if (slot_free) begin
            deliver      = 1'b1;
            deliver_data = hold_q;
          end
        end
        StDrop: begin
          if (imem_rsp_valid) begin
            state_d = StReq;
          end
        end
        default: begin
          state_d = StReset;
        end
      endcase

      // pc_q is still the address of the word being delivered; advance only now.
      if (deliver) begin
        if_valid_d = 1'b1;
        if_instr_d = deliver_data;
        if_pc_d    = pc_q;
        pc_d       = pc_q + 32'd4;
        state_d    = StReq;
      end
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StReset;
      pc_q       <= align_word(RESET_PC);
      hold_q     <= InstrNop;
      if_valid_q <= 1'b0;
      if_instr_q <= InstrNop;
      if_pc_q    <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      hold_q     <= hold_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
    end
  end

  // Request is a pure function of state so it stays stable while ready is low.
  always_comb begin
    imem_req_valid = (state_q == StReq);
    imem_req_addr  = pc_q;
    if_valid       = if_valid_q;
    if_instr       = if_instr_q;
    if_pc          = if_pc_q;
    if_pc_plus4    = if_pc_q + 32'd4;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a hand-driven 1-cycle instruction memory.
module tb_fetch_unit;
  import riscv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_count = 0;
  int hs_base  = 0;

  fetch_unit #(
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr (imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .stall         (stall),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .if_pc_plus4   (if_pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count accepted requests.
  always @(posedge clk) begin
    if (rst_n && imem_req_valid && imem_req_ready) hs_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    stall          = 1'b0;
    tick();
    tick();

    // Reset values
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_instr", if_instr, 32'h0000_0013);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_pc_plus4", if_pc_plus4, 32'h4);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);

    // E0: RESET -> REQ
    rst_n = 1'b1;
    tick();
    check("e0_req_valid", 32'(imem_req_valid), 32'd1);
    check("e0_req_addr", imem_req_addr, 32'h0);
    // E1: handshake
    tick();
    check("e1_req_valid", 32'(imem_req_valid), 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0050_0093;
    // E2: first word
    tick();
    imem_rsp_valid = 1'b0;
    check("e2_if_valid", 32'(if_valid), 32'd1);
    check("e2_if_pc", if_pc, 32'h0);
    check("e2_if_instr", if_instr, 32'h0050_0093);
    check("e2_pc_plus4", if_pc_plus4, 32'h4);
    check("e2_req_addr", imem_req_addr, 32'h4);
    // E3: handshake, word consumed
    tick();
    check("e3_if_valid", 32'(if_valid), 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h00A0_0113;
    // E4: second word
    tick();
    imem_rsp_valid = 1'b0;
    check("e4_if_valid", 32'(if_valid), 32'd1);
    check("e4_if_pc", if_pc, 32'h4);
    check("e4_pc_plus4", if_pc_plus4, 32'h8);
    check("e4_if_instr", if_instr, 32'h00A0_0113);

    // Stall for 5 cycles while the next response arrives
    stall = 1'b1;
    tick();  // E5: handshake at 0x8
    check("e5_if_valid", 32'(if_valid), 32'd1);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0010_0193;
    tick();  // E6: captured into hold buffer
    imem_rsp_valid = 1'b0;
    check("e6_state", 32'(dut.state_q), 32'(StHold));
    check("e6_req_valid", 32'(imem_req_valid), 32'd0);
    check("e6_if_instr", if_instr, 32'h00A0_0113);
    check("e6_if_pc", if_pc, 32'h4);
    tick();  // E7
    check("e7_req_valid", 32'(imem_req_valid), 32'd0);
    check("e7_if_instr", if_instr, 32'h00A0_0113);
    tick();  // E8
    check("e8_state", 32'(dut.state_q), 32'(StHold));
    tick();  // E9
    check("e9_if_instr", if_instr, 32'h00A0_0113);
    check("e9_req_valid", 32'(imem_req_valid), 32'd0);
    stall = 1'b0;
    tick();  // E10: held word delivered
    check("e10_if_valid", 32'(if_valid), 32'd1);
    check("e10_if_pc", if_pc, 32'h8);
    check("e10_if_instr", if_instr, 32'h0010_0193);
    check("e10_req_valid", 32'(imem_req_valid), 32'd1);
    check("e10_req_addr", imem_req_addr, 32'hC);
    tick();  // E11: handshake at 0xC, now WAIT
    check("e11_if_valid", 32'(if_valid), 32'd0);

    // Redirect while WAIT; stale response must be dropped
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    tick();  // E12
    redirect_valid = 1'b0;
    check("e12_state", 32'(dut.state_q), 32'(StDrop));
    check("e12_req_valid", 32'(imem_req_valid), 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    tick();  // E13: stale word dropped
    imem_rsp_valid = 1'b0;
    check("e13_if_valid", 32'(if_valid), 32'd0);
    check("e13_req_valid", 32'(imem_req_valid), 32'd1);
    check("e13_req_addr", imem_req_addr, 32'h100);
    tick();  // E14: handshake
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0030_0213;
    tick();  // E15
    imem_rsp_valid = 1'b0;
    check("e15_if_valid", 32'(if_valid), 32'd1);
    check("e15_if_pc", if_pc, 32'h100);
    check("e15_if_instr", if_instr, 32'h0030_0213);

    // Redirect coinciding with a response: no DROP, data never shown
    tick();  // E16: handshake at 0x104
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1111_1111;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    tick();  // E17
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    check("e17_state", 32'(dut.state_q), 32'(StReq));
    check("e17_if_valid", 32'(if_valid), 32'd0);
    check("e17_req_valid", 32'(imem_req_valid), 32'd1);
    check("e17_req_addr", imem_req_addr, 32'h200);
    tick();  // E18: handshake
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0040_0293;
    tick();  // E19
    imem_rsp_valid = 1'b0;
    check("e19_if_pc", if_pc, 32'h200);
    check("e19_if_instr", if_instr, 32'h0040_0293);

    // Ready low for 3 cycles: address stable, single acceptance
    imem_req_ready = 1'b0;
    hs_base        = hs_count;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("nrdy_req_valid", 32'(imem_req_valid), 32'd1);
      check("nrdy_req_addr", imem_req_addr, 32'h204);
    end
    imem_req_ready = 1'b1;
    tick();  // handshake
    check("rdy_req_valid", 32'(imem_req_valid), 32'd0);
    tick();  // still waiting, no response
    check("rdy_state", 32'(dut.state_q), 32'(StWait));
    check("rdy_hs_count", 32'(hs_count - hs_base), 32'd1);

    // Reset in WAIT, then a late response
    rst_n = 1'b0;
    tick();
    check("mrst_if_valid", 32'(if_valid), 32'd0);
    check("mrst_if_instr", if_instr, 32'h0000_0013);
    check("mrst_if_pc", if_pc, 32'h0);
    check("mrst_req_valid", 32'(imem_req_valid), 32'd0);
    rst_n          = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hCAFE_F00D;
    tick();  // E0 again, late response ignored
    imem_rsp_valid = 1'b0;
    check("mrst_e0_if_valid", 32'(if_valid), 32'd0);
    check("mrst_e0_req_valid", 32'(imem_req_valid), 32'd1);
    check("mrst_e0_req_addr", imem_req_addr, 32'h0);
    tick();  // handshake
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0050_0093;
    tick();
    imem_rsp_valid = 1'b0;
    check("mrst_if_valid2", 32'(if_valid), 32'd1);
    check("mrst_if_pc2", if_pc, 32'h0);
    check("mrst_if_instr2", if_instr, 32'h0050_0093);

    // Redirect with a same-cycle handshake -> DROP; then PC wrap
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    check("wrap_state", 32'(dut.state_q), 32'(StDrop));
    check("wrap_if_valid", 32'(if_valid), 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h2222_2222;
    tick();
    imem_rsp_valid = 1'b0;
    check("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    tick();  // handshake
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0060_0313;
    tick();
    imem_rsp_valid = 1'b0;
    check("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    check("wrap_pc_plus4", if_pc_plus4, 32'h0);
    check("wrap_next_addr", imem_req_addr, 32'h0);
    check("wrap_if_instr", if_instr, 32'h0060_0313);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RISC-V core. It holds the program counter, issues one word-aligned request at a time to instruction memory, and presents each returned instruction with its PC to the decode stage. The decode stage feeds `instr` into the immediate generator. Branch/jump redirects from execute flush the stage and restart fetch at the new PC.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; synchronous and active-low.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_addr`  out  32  fetch address; bits [1:0] are always 0.
- `imem_req_ready`  in  1  memory accepts the request when both valid and ready are high.
- `imem_rsp_valid`  in  1  one-cycle pulse carrying the data for the single outstanding request.
- `imem_rsp_data`  in  32  instruction word.
- `redirect_valid`  in  1  flush request from execute; takes priority over all other events.
- `redirect_pc`  in  32  new PC; bits [1:0] are ignored and treated as 0.
- `stall`  in  1  decode cannot accept an instruction this cycle.
- `if_valid`  out  1  `if_instr`/`if_pc` hold a valid instruction.
- `if_instr`  out  32  instruction to decode.
- `if_pc`  out  32  PC of `if_instr`.
- `if_pc_plus4`  out  32  `if_pc + 4`, combinational, mod 2^32.

## Operation
- State machine states: RESET, REQ, WAIT, HOLD, DROP. `pc` is the next fetch address.
- Reset (`rst_n`=0 at an edge), from any state and mid-transaction:
  - state=RESET, pc=`RESET_PC`.
  - `if_valid`=0, `if_instr`=32'h0000_0013 (NOP), `if_pc`=`RESET_PC`.
  - `imem_req_valid`=0.
  - Any response already in flight is forgotten.
- RESET: state goes to REQ on the next edge.
- REQ: `imem_req_valid`=1, `imem_req_addr`=pc. On handshake, state goes to WAIT.
- WAIT: when `imem_rsp_valid`=1:
  - If the output slot is free (`!if_valid || !stall`): load `if_instr`=data, `if_pc`=pc, `if_valid`=1; pc=pc+4; state goes to REQ.
  - Otherwise: capture the data in the hold buffer; state goes to HOLD.
- HOLD: `imem_req_valid`=0. When the slot frees, move the buffer to the outputs; pc=pc+4; state goes to REQ.
- Decode consumption: decode takes the instruction in any cycle with `if_valid && !stall`. If nothing new loads in that cycle, `if_valid` drops to 0.
- While `if_valid && stall`, `if_instr`/`if_pc` stay stable.
- Redirect (`redirect_valid`=1, not in reset):
  - pc=`redirect_pc` & ~3; `if_valid`=0; hold buffer discarded.
  - Next state is DROP if a request is outstanding and unanswered. This covers WAIT without `rsp_valid`, and REQ with a handshake in the same cycle.
  - Otherwise the next state is REQ. This includes a response arriving in the same cycle, which is discarded.
- DROP: `imem_req_valid`=0. Discard the next `imem_rsp_valid`, then go to REQ. A further redirect in DROP updates pc and stays in DROP.
- PC arithmetic is 32-bit and wraps: 32'hFFFF_FFFC + 4 = 0.
- At most one outstanding memory request at any time.

## Timing
- E0 is the first edge with `rst_n`=1.
- Sequence with `imem_req_ready`=1 and 1-cycle memory latency:
  - E0: RESET goes to REQ.
  - E1: handshake.
  - E2: response is captured, so `if_valid`=1 after E2.
- Steady-state throughput is one instruction every 2 cycles.
- Fetch latency equals memory latency + 1 cycle.
- Redirect at edge En with memory idle: the request for the new PC is visible after En, and its instruction is valid 2 edges later with a 1-cycle memory.
- `imem_req_addr` and `imem_req_valid` stay stable while waiting for ready.

## Structure
- Shared package `riscv_pkg` holds the NOP constant 32'h0000_0013, the opcode constants (OP-IMM, LOAD, STORE, …) also used by the immediate generator, and the fetch state enum.
- The hold buffer and FSM stay inline. No sub-module is required.

## Test plan
- Reset release, `RESET_PC`=0, memory always ready, 1-cycle latency, words 0x00500093/0x00A00113 -> `if_valid` after E2 with `if_pc`=0, then `if_pc`=4 two cycles later; `if_pc_plus4`=4/8.
- `stall` held 5 cycles while a response arrives -> state is HOLD, no new request issued, `if_instr` stable; after release the held word appears, then fetch resumes at pc+4.
- `redirect_valid` with `redirect_pc`=0x103 while in WAIT -> the stale response is dropped, the next request address is 0x100, the first delivered `if_pc`=0x100.
- Redirect in the same cycle as `imem_rsp_valid` -> that data is never presented; the next request goes to the redirect PC with no DROP.
- `imem_req_ready`=0 for 3 cycles -> address held constant, exactly one request accepted.
- `rst_n`=0 mid-WAIT, followed by a late response pulse -> all outputs return to reset values and fetch restarts at `RESET_PC`.
